// File: rtl/cnt_ctrl.sv
// Run controller for the up-counter datapath: turns the divided clock into
// count-enable pulses and sequences start/pause/stop/terminal count.
module cnt_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             cnt_ctrl_fsys,
    input  logic             cnt_ctrl_rst,
    input  logic             cnt_ctrl_tick_in,
    input  logic             cnt_ctrl_start,
    input  logic             cnt_ctrl_stop,
    input  logic             cnt_ctrl_pause,
    input  logic             cnt_ctrl_mode,
    input  logic [WIDTH-1:0] cnt_ctrl_limit,
    output logic [WIDTH-1:0] cnt_ctrl_count,
    output logic             cnt_ctrl_en,
    output logic             cnt_ctrl_clr,
    output logic             cnt_ctrl_wrap,
    output logic             cnt_ctrl_done,
    output logic             cnt_ctrl_busy,
    output logic [1:0]       cnt_ctrl_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_limit;
    logic             r_mode;
    logic             r_tick_d;
    logic             r_en;
    logic             r_clr;
    logic             r_wrap;
    logic             r_done;
    logic             r_busy;
    logic             w_rise;

    // tick_d follows tick_in unconditionally, so a level already high on RUN entry never pulses
    assign w_rise = cnt_ctrl_tick_in & ~r_tick_d;

    always_ff @(posedge cnt_ctrl_fsys or posedge cnt_ctrl_rst) begin
        if (cnt_ctrl_rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_limit  <= '0;
            r_mode   <= 1'b0;
            r_tick_d <= 1'b0;
            r_en     <= 1'b0;
            r_clr    <= 1'b0;
            r_wrap   <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_tick_d <= cnt_ctrl_tick_in;
            r_en     <= 1'b0;
            r_clr    <= 1'b0;
            r_wrap   <= 1'b0;
            // Priority in every state: stop > start > pause > rise
            if (cnt_ctrl_stop) begin
                r_state <= ST_IDLE;
                r_done  <= 1'b0;
                r_busy  <= 1'b0;
            end else if (cnt_ctrl_start) begin
                r_state <= ST_RUN;
                r_count <= '0;
                r_clr   <= 1'b1;
                r_limit <= cnt_ctrl_limit;
                r_mode  <= cnt_ctrl_mode;
                r_done  <= 1'b0;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (cnt_ctrl_pause) begin
                            r_state <= ST_PAUSE;
                        end else if (w_rise) begin
                            if (r_count != r_limit) begin
                                r_count <= r_count + WIDTH'(1);
                                r_en    <= 1'b1;
                            end else if (r_mode) begin
                                r_count <= '0;
                                r_en    <= 1'b1;
                                r_wrap  <= 1'b1;
                            end else begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        // A rise coincident with pause release is dropped
                        if (!cnt_ctrl_pause) begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign cnt_ctrl_count = r_count;
    assign cnt_ctrl_en    = r_en;
    assign cnt_ctrl_clr   = r_clr;
    assign cnt_ctrl_wrap  = r_wrap;
    assign cnt_ctrl_done  = r_done;
    assign cnt_ctrl_busy  = r_busy;
    assign cnt_ctrl_state = r_state;

endmodule

// File: tb/tb_cnt_ctrl.sv
// Directed self-checking bench for cnt_ctrl (WIDTH=8).
module tb_cnt_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick_in;
    logic             start;
    logic             stop;
    logic             pause;
    logic             mode;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             en;
    logic             clr;
    logic             wrap;
    logic             done;
    logic             busy;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    cnt_ctrl #(.WIDTH(WIDTH)) dut (
        .cnt_ctrl_fsys    (clk),
        .cnt_ctrl_rst     (rst),
        .cnt_ctrl_tick_in (tick_in),
        .cnt_ctrl_start   (start),
        .cnt_ctrl_stop    (stop),
        .cnt_ctrl_pause   (pause),
        .cnt_ctrl_mode    (mode),
        .cnt_ctrl_limit   (limit),
        .cnt_ctrl_count   (count),
        .cnt_ctrl_en      (en),
        .cnt_ctrl_clr     (clr),
        .cnt_ctrl_wrap    (wrap),
        .cnt_ctrl_done    (done),
        .cnt_ctrl_busy    (busy),
        .cnt_ctrl_state   (state)
    );

    always #5 clk = ~clk;

    // Advance one clock; observe 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rise();
        tick_in = 1'b1;
        step();
    endtask

    task automatic fall();
        tick_in = 1'b0;
        step();
    endtask

    task automatic do_start(input logic [WIDTH-1:0] lim, input logic md);
        limit = lim;
        mode  = md;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick_in = ~tick_in;
            step();
            checks++; if (en !== 1'b0 || state !== 2'b00 || count !== 8'd0) begin errors++; $display("FAIL reset_hold: en=%b state=%b count=%0d exp en=0 state=00 count=0", en, state, count); end
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick_in = ~tick_in;
            step();
            checks++; if (en !== 1'b0 || state !== 2'b00) begin errors++; $display("FAIL idle_ticks: en=%b state=%b exp en=0 state=00", en, state); end
        end
        checks++; if ({busy, done, clr, wrap} !== 4'b0000 || count !== 8'd0) begin errors++; $display("FAIL idle_outputs: busy/done/clr/wrap=%b count=%0d exp 0000 count=0", {busy, done, clr, wrap}, count); end
        tick_in = 1'b0;
        step();
    endtask

    task automatic test_one_shot();
        logic [WIDTH-1:0] exp_cnt;
        do_start(8'd3, 1'b0);
        checks++; if (clr !== 1'b1 || count !== 8'd0 || state !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL oneshot_start: clr=%b count=%0d state=%b busy=%b exp clr=1 count=0 state=01 busy=1", clr, count, state, busy); end
        for (int i = 1; i <= 5; i++) begin
            rise();
            if (i <= 3) begin
                exp_cnt = WIDTH'(i);
                checks++; if (en !== 1'b1 || count !== exp_cnt || state !== 2'b01) begin errors++; $display("FAIL oneshot_rise%0d: en=%b count=%0d state=%b exp en=1 count=%0d state=01", i, en, count, state, exp_cnt); end
            end else begin
                checks++; if (en !== 1'b0 || count !== 8'd3 || state !== 2'b11 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL oneshot_done%0d: en=%b count=%0d state=%b done=%b busy=%b exp en=0 count=3 state=11 done=1 busy=0", i, en, count, state, done, busy); end
            end
            fall();
            checks++; if (en !== 1'b0) begin errors++; $display("FAIL oneshot_fall%0d: en=%b exp 0", i, en); end
        end
    endtask

    task automatic test_wrap();
        int exp_cnt [7] = '{1, 2, 0, 1, 2, 0, 1};
        logic exp_wrap;
        do_start(8'd2, 1'b1);
        checks++; if (clr !== 1'b1 || count !== 8'd0 || done !== 1'b0 || state !== 2'b01) begin errors++; $display("FAIL wrap_start: clr=%b count=%0d done=%b state=%b exp clr=1 count=0 done=0 state=01", clr, count, done, state); end
        for (int i = 0; i < 7; i++) begin
            exp_wrap = (i == 2 || i == 5);
            rise();
            checks++; if (en !== 1'b1 || wrap !== exp_wrap || count !== WIDTH'(exp_cnt[i])) begin errors++; $display("FAIL wrap_rise%0d: en=%b wrap=%b count=%0d exp en=1 wrap=%b count=%0d", i + 1, en, wrap, count, exp_wrap, exp_cnt[i]); end
            fall();
        end
    endtask

    task automatic test_pause_priority();
        do_start(8'd10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rise();
            fall();
        end
        checks++; if (count !== 8'd4) begin errors++; $display("FAIL pause_pre: count=%0d exp 4", count); end
        pause = 1'b1;
        rise();
        checks++; if (count !== 8'd4 || state !== 2'b10 || en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL pause_enter: count=%0d state=%b en=%b busy=%b exp count=4 state=10 en=0 busy=1", count, state, en, busy); end
        fall();
        for (int i = 0; i < 2; i++) begin
            rise();
            checks++; if (count !== 8'd4 || en !== 1'b0 || state !== 2'b10) begin errors++; $display("FAIL pause_drop%0d: count=%0d en=%b state=%b exp count=4 en=0 state=10", i, count, en, state); end
            fall();
        end
        pause = 1'b0;
        step();
        checks++; if (state !== 2'b01 || count !== 8'd4) begin errors++; $display("FAIL pause_release: state=%b count=%0d exp state=01 count=4", state, count); end
        rise();
        checks++; if (count !== 8'd5 || en !== 1'b1) begin errors++; $display("FAIL pause_resume: count=%0d en=%b exp count=5 en=1", count, en); end
        fall();
        stop  = 1'b1;
        start = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b0;
        checks++; if (state !== 2'b00 || clr !== 1'b0 || count !== 8'd5 || busy !== 1'b0) begin errors++; $display("FAIL stop_start: state=%b clr=%b count=%0d busy=%b exp state=00 clr=0 count=5 busy=0", state, clr, count, busy); end
    endtask

    task automatic test_restart();
        do_start(8'd10, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rise();
            fall();
        end
        checks++; if (count !== 8'd6) begin errors++; $display("FAIL restart_pre: count=%0d exp 6", count); end
        limit = 8'd1;
        rise();
        checks++; if (count !== 8'd7 || en !== 1'b1 || state !== 2'b01) begin errors++; $display("FAIL limit_live: count=%0d en=%b state=%b exp count=7 en=1 state=01", count, en, state); end
        fall();
        do_start(8'd1, 1'b0);
        checks++; if (clr !== 1'b1 || count !== 8'd0 || state !== 2'b01) begin errors++; $display("FAIL restart_clr: clr=%b count=%0d state=%b exp clr=1 count=0 state=01", clr, count, state); end
        rise();
        checks++; if (count !== 8'd1 || en !== 1'b1) begin errors++; $display("FAIL restart_rise1: count=%0d en=%b exp count=1 en=1", count, en); end
        fall();
        rise();
        checks++; if (state !== 2'b11 || done !== 1'b1 || count !== 8'd1 || en !== 1'b0) begin errors++; $display("FAIL restart_done: state=%b done=%b count=%0d en=%b exp state=11 done=1 count=1 en=0", state, done, count, en); end
        fall();
    endtask

    task automatic test_reset_midrun();
        do_start(8'd20, 1'b0);
        for (int i = 0; i < 7; i++) begin
            fall();
            rise();
        end
        checks++; if (count !== 8'd7 || en !== 1'b1) begin errors++; $display("FAIL midrun_pre: count=%0d en=%b exp count=7 en=1", count, en); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (count !== 8'd0 || state !== 2'b00 || {en, clr, wrap, done, busy} !== 5'b00000) begin errors++; $display("FAIL async_reset: count=%0d state=%b en/clr/wrap/done/busy=%b exp count=0 state=00 00000", count, state, {en, clr, wrap, done, busy}); end
        step();
        rst = 1'b0;
        step();
        do_start(8'd20, 1'b0);
        checks++; if (clr !== 1'b1 || state !== 2'b01) begin errors++; $display("FAIL post_reset_start: clr=%b state=%b exp clr=1 state=01", clr, state); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (en !== 1'b0 || count !== 8'd0) begin errors++; $display("FAIL high_tick_nopulse%0d: en=%b count=%0d exp en=0 count=0", i, en, count); end
        end
        fall();
        rise();
        checks++; if (en !== 1'b1 || count !== 8'd1) begin errors++; $display("FAIL real_edge: en=%b count=%0d exp en=1 count=1", en, count); end
        fall();
    endtask

    task automatic test_limit_zero();
        do_start(8'd0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            rise();
            checks++; if (en !== 1'b1 || wrap !== 1'b1 || count !== 8'd0) begin errors++; $display("FAIL lim0_wrap%0d: en=%b wrap=%b count=%0d exp en=1 wrap=1 count=0", i, en, wrap, count); end
            fall();
        end
        do_start(8'd0, 1'b0);
        rise();
        checks++; if (state !== 2'b11 || count !== 8'd0 || en !== 1'b0) begin errors++; $display("FAIL lim0_oneshot: state=%b count=%0d en=%b exp state=11 count=0 en=0", state, count, en); end
        fall();
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++; if (state !== 2'b00 || done !== 1'b0) begin errors++; $display("FAIL done_stop: state=%b done=%b exp state=00 done=0", state, done); end
    endtask

    initial begin
        rst     = 1'b1;
        tick_in = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        pause   = 1'b0;
        mode    = 1'b0;
        limit   = '0;
        #1;
        checks++; if (state !== 2'b00 || count !== 8'd0 || en !== 1'b0) begin errors++; $display("FAIL reset_initial: state=%b count=%0d en=%b exp state=00 count=0 en=0", state, count, en); end
        test_reset();
        test_one_shot();
        test_wrap();
        test_pause_priority();
        test_restart();
        test_reset_midrun();
        test_limit_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnt_ctrl.md
Name: cnt_ctrl

Overview:
- Run controller for the up-counter datapath; sits between the clock-generator output and the counter.
- Edge-detects the slow divided clock (a level signal in the fsys domain) and turns it into single-cycle count-enable pulses.
- Sequences start, pause, stop and terminal count through a 4-state FSM, in one-shot or wrap mode.
- Keeps the authoritative count value.

Parameters:
WIDTH, 8, width of count and limit.

Ports:
cnt_ctrl_fsys  input  1  system clock; all logic on its rising edge.
cnt_ctrl_rst  input  1  reset, asynchronous, active-high.
cnt_ctrl_tick_in  input  1  divided clock from the clock generator; fsys-synchronous level.
cnt_ctrl_start  input  1  start/restart request, level-sampled each cycle.
cnt_ctrl_stop  input  1  stop request, level-sampled each cycle.
cnt_ctrl_pause  input  1  pause while high.
cnt_ctrl_mode  input  1  0 = one-shot, 1 = wrap; sampled at start.
cnt_ctrl_limit  input  WIDTH  terminal count; sampled at start.
cnt_ctrl_count  output  WIDTH  current count.
cnt_ctrl_en  output  1  one-cycle pulse when count advances or wraps.
cnt_ctrl_clr  output  1  one-cycle pulse when count is cleared by start.
cnt_ctrl_wrap  output  1  one-cycle pulse on wrap (mode 1).
cnt_ctrl_done  output  1  high while in DONE.
cnt_ctrl_busy  output  1  high in RUN or PAUSE.
cnt_ctrl_state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Behaviour:
- Clocking and reset: one clock, cnt_ctrl_fsys. cnt_ctrl_rst is asynchronous and active-high. Reset asserted at any time, including mid-run, forces:
  - state IDLE; count 0;
  - en, clr, wrap, done, busy all 0;
  - the tick_d register 0 and the limit/mode registers 0.
- Edge detect:
  - tick_d <= tick_in every cycle, in every state.
  - rise = tick_in & ~tick_d.
  - A tick_in that is already high when RUN is entered produces no pulse until its next real rising edge.
- Registered outputs:
  - All outputs are registered.
  - en, clr and wrap default to 0 each cycle and are 1 only in the cycle after the triggering condition is sampled. That is the same cycle count shows its new value.
- Input priority (every state): stop > start > pause > rise.
- IDLE:
  - start -> RUN: count <= 0, clr = 1, limit_q <= limit, mode_q <= mode.
  - stop, pause and rise are ignored.
- RUN, evaluated in priority order:
  - stop -> IDLE, count held.
  - start -> restart: count <= 0, clr = 1, limit and mode resampled, stay in RUN.
  - pause -> PAUSE; a rise in the same cycle is dropped.
  - rise with count != limit_q -> count+1, en = 1.
  - rise with count == limit_q and mode_q = 1 -> count <= 0, en = 1, wrap = 1.
  - rise with count == limit_q and mode_q = 0 -> DONE, count held at limit_q, en = 0.
- PAUSE:
  - All rises are dropped; count held.
  - stop -> IDLE.
  - start -> RUN with clear (as in IDLE).
  - pause low -> RUN; a rise in that same cycle is dropped.
- DONE:
  - done = 1; count held.
  - start -> RUN with clear.
  - stop -> IDLE.
  - pause and rise are ignored.
- Outputs:
  - busy = (state == RUN or PAUSE), registered alongside state.
  - done = (state == DONE).
- Limit rules:
  - limit_q = 0, mode 0: the first rise goes to DONE with count 0.
  - limit_q = 0, mode 1: every rise gives en = 1, wrap = 1, count stays 0.
  - limit = 2^WIDTH-1 is legal; count never overflows past limit_q.
  - Changes to limit or mode while running have no effect until the next start.
- Latency: rising edge on tick_in sampled at cycle N -> count, en and wrap updated at cycle N+1.

Test Plan:
- Reset then idle: rst pulse mid-cycle, tick toggling -> state 00, count 0, en never 1; async clear seen before the next clock edge.
- One-shot: WIDTH=8, limit=3, mode=0, start, 5 tick rises -> en pulses on rises 1-3 with count 1,2,3; rise 4 -> state 11, done=1, count 3; rise 5 ignored.
- Wrap: limit=2, mode=1, 7 rises -> count 1,2,0,1,2,0,1; wrap=1 exactly on rises 3 and 6; en on all 7.
- Pause/priority:
  - During RUN at count 4, raise pause in the same cycle as a rise -> count stays 4, state 10.
  - Two rises while paused are dropped.
  - Drop pause -> state 01; next rise gives count 5.
  - Assert stop and start together -> state 00.
- Restart and resample: in RUN at count 6, limit changed to 1 -> no effect. Then start -> clr=1, count 0; new limit 1 applies (second rise goes DONE).
- Reset mid-run: count 7 in RUN, assert rst -> all outputs 0, state 00. Release with tick_in high -> no en after a subsequent start until tick_in falls and rises again.
